// File: rtl/mips_multicycle.sv
// mips_multicycle: FSM-sequenced MIPS subset core with an internal 32x32
// register file and a single shared instruction/data memory port using a
// req/ack handshake that tolerates arbitrary wait states (with watchdog).
module mips_multicycle #(
  parameter logic [31:0] PC_INIT  = 32'h0,
  parameter logic [31:0] SP_INIT  = 32'h0,
  parameter logic [31:0] RA_INIT  = 32'h0,
  parameter int          MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] pc_out,
  output logic        retire,
  output logic        halted,
  output logic        fault
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // Last stalled-cycle count before the watchdog trips (unused when disabled).
  localparam logic [31:0] WD_LAST = (MAX_WAIT == 0) ? 32'h0 : 32'(MAX_WAIT - 1);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [3:0] {K_ALU, K_ADDIU, K_LW, K_SW, K_BR, K_J, K_JR, K_BRK, K_ILL} kind_t;

  state_t      state_q;
  logic [31:0] pc_q, ir_q, a_q, b_q, imm_q, alu_q, mdr_q, wd_q;
  logic [31:0] rf_q [32];
  logic        mem_req_q, mem_we_q, retire_q, halted_q, fault_q;
  logic [31:0] mem_addr_q, mem_wdata_q;

  kind_t       kind_d;
  logic [31:0] alu_d, pc_next_d;

  logic [5:0]  op_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s, shamt_s, wb_addr_s;
  logic [31:0] pc_plus4_s, br_off_s, wb_data_s;
  logic        wd_expired_s;

  assign op_s         = ir_q[31:26];
  assign rs_s         = ir_q[25:21];
  assign rt_s         = ir_q[20:16];
  assign rd_s         = ir_q[15:11];
  assign shamt_s      = ir_q[10:6];
  assign funct_s      = ir_q[5:0];
  assign pc_plus4_s   = pc_q + 32'd4;
  assign br_off_s     = {imm_q[29:0], 2'b00};
  assign wb_addr_s    = (op_s == OP_RTYPE) ? rd_s : rt_s;
  assign wb_data_s    = (op_s == OP_LW) ? mdr_q : alu_q;
  assign wd_expired_s = (MAX_WAIT != 0) && (wd_q == WD_LAST);

  // Instruction classification, ALU result and control-flow target for EXEC.
  always_comb begin
    kind_d    = K_ILL;
    alu_d     = 32'h0;
    pc_next_d = pc_plus4_s;
    case (op_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADDU:  begin kind_d = K_ALU; alu_d = a_q + b_q; end
          FN_SUBU:  begin kind_d = K_ALU; alu_d = a_q - b_q; end
          FN_AND:   begin kind_d = K_ALU; alu_d = a_q & b_q; end
          FN_OR:    begin kind_d = K_ALU; alu_d = a_q | b_q; end
          FN_SLT:   begin kind_d = K_ALU; alu_d = {31'h0, $signed(a_q) < $signed(b_q)}; end
          FN_SLL:   begin kind_d = K_ALU; alu_d = b_q << shamt_s; end
          FN_JR:    begin kind_d = K_JR;  pc_next_d = a_q; end
          FN_BREAK: kind_d = K_BRK;
          default:  kind_d = K_ILL;
        endcase
      end
      OP_ADDIU: begin kind_d = K_ADDIU; alu_d = a_q + imm_q; end
      OP_LW:    begin kind_d = K_LW;    alu_d = a_q + imm_q; end
      OP_SW:    begin kind_d = K_SW;    alu_d = a_q + imm_q; end
      OP_BEQ: begin
        kind_d = K_BR;
        if (a_q == b_q) pc_next_d = pc_plus4_s + br_off_s;
        else            pc_next_d = pc_plus4_s;
      end
      OP_BNE: begin
        kind_d = K_BR;
        if (a_q != b_q) pc_next_d = pc_plus4_s + br_off_s;
        else            pc_next_d = pc_plus4_s;
      end
      OP_J:    begin kind_d = K_J; pc_next_d = {pc_plus4_s[31:28], ir_q[25:0], 2'b00}; end
      default: kind_d = K_ILL;
    endcase
  end

  // Main sequencer: state, PC, register file, memory port and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH;
      pc_q        <= PC_INIT;
      ir_q        <= 32'h0;
      a_q         <= 32'h0;
      b_q         <= 32'h0;
      imm_q       <= 32'h0;
      alu_q       <= 32'h0;
      mdr_q       <= 32'h0;
      wd_q        <= 32'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      retire_q    <= 1'b0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        if (i == 29)      rf_q[i] <= SP_INIT;
        else if (i == 31) rf_q[i] <= RA_INIT;
        else              rf_q[i] <= 32'h0;
      end
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        FETCH: begin
          // Entered with mem_req low only after reset or a store ack (idle gap).
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= pc_q;
            wd_q       <= 32'h0;
          end else if (mem_ack) begin
            ir_q      <= mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= DECODE;
          end else if (wd_expired_s) begin
            mem_req_q <= 1'b0;
            halted_q  <= 1'b1;
            fault_q   <= 1'b1;
            state_q   <= HALT;
          end else begin
            wd_q <= wd_q + 32'd1;
          end
        end
        DECODE: begin
          a_q     <= rf_q[rs_s];
          b_q     <= rf_q[rt_s];
          imm_q   <= {{16{ir_q[15]}}, ir_q[15:0]};
          state_q <= EXEC;
        end
        EXEC: begin
          case (kind_d)
            K_ALU, K_ADDIU: begin
              alu_q   <= alu_d;
              state_q <= WB;
            end
            K_LW, K_SW: begin
              if (alu_d[1:0] != 2'b00) begin
                halted_q <= 1'b1;
                fault_q  <= 1'b1;
                state_q  <= HALT;
              end else begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= (kind_d == K_SW);
                mem_addr_q  <= alu_d;
                mem_wdata_q <= b_q;
                wd_q        <= 32'h0;
                state_q     <= MEM;
              end
            end
            K_BR, K_J, K_JR: begin
              pc_q       <= pc_next_d;
              retire_q   <= 1'b1;
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= pc_next_d;
              wd_q       <= 32'h0;
              state_q    <= FETCH;
            end
            K_BRK: begin
              halted_q <= 1'b1;
              state_q  <= HALT;
            end
            default: begin
              halted_q <= 1'b1;
              fault_q  <= 1'b1;
              state_q  <= HALT;
            end
          endcase
        end
        MEM: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (mem_we_q) begin
              pc_q     <= pc_plus4_s;
              retire_q <= 1'b1;
              state_q  <= FETCH;
            end else begin
              mdr_q   <= mem_rdata;
              state_q <= WB;
            end
          end else if (wd_expired_s) begin
            mem_req_q <= 1'b0;
            halted_q  <= 1'b1;
            fault_q   <= 1'b1;
            state_q   <= HALT;
          end else begin
            wd_q <= wd_q + 32'd1;
          end
        end
        WB: begin
          if (wb_addr_s != 5'd0) rf_q[wb_addr_s] <= wb_data_s;
          pc_q       <= pc_plus4_s;
          retire_q   <= 1'b1;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= pc_plus4_s;
          wd_q       <= 32'h0;
          state_q    <= FETCH;
        end
        HALT: state_q <= HALT;
        default: begin
          halted_q <= 1'b1;
          fault_q  <= 1'b1;
          state_q  <= HALT;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc_out    = pc_q;
  assign retire    = retire_q;
  assign halted    = halted_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_mips_multicycle.sv
// Scoreboard bench for mips_multicycle: stimulus pushes expected retires and
// stores; a monitor and a variable-latency memory model pop and compare.
module tb_mips_multicycle;

  localparam logic [31:0] PC_INIT  = 32'h0;
  localparam logic [31:0] SP_INIT  = 32'h0000_1000;
  localparam logic [31:0] RA_INIT  = 32'h0000_0040;
  localparam int          MAX_WAIT = 16;
  localparam logic [31:0] BRK      = 32'h0000_000D;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req, mem_we, mem_ack, retire, halted, fault;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

  logic [31:0] mem [256];
  int          checks = 0;
  int          failures = 0;
  int          fetch_delay = 0, data_delay = 0;
  bit          hang_fetch = 1'b0, hang_data = 1'b0;
  int          retire_cnt = 0, data_req_cnt = 0, cyc = 0;
  logic [31:0] exp_pc_q[$];
  int          exp_gap_q[$];
  logic [31:0] exp_wa_q[$], exp_wd_q[$];

  mips_multicycle #(
    .PC_INIT(PC_INIT), .SP_INIT(SP_INIT), .RA_INIT(RA_INIT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .pc_out(pc_out), .retire(retire), .halted(halted),
    .fault(fault)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_t(input int rs, input int rt, input int rd,
                                      input int sh, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] i_t(input logic [5:0] op, input int rs, input int rt,
                                      input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic exp_ret(input logic [31:0] pc, input int gap);
    exp_pc_q.push_back(pc);
    exp_gap_q.push_back(gap);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    exp_wa_q.push_back(a);
    exp_wd_q.push_back(d);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'hFC00_0000;
  endtask

  // Retire monitor: pops expected PC and cycle spacing on every retire pulse.
  initial begin
    int          last;
    logic [31:0] ep;
    int          eg;
    last = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        last = -1;
        retire_cnt = 0;
      end else if (retire) begin
        retire_cnt++;
        if (exp_pc_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_retire: actual pc_out=%h required no retire", pc_out);
        end else begin
          ep = exp_pc_q.pop_front();
          eg = exp_gap_q.pop_front();
          chk("retire_pc", pc_out, ep);
          if (eg != 0 && last >= 0) chk("retire_gap", 32'(cyc - last), 32'(eg));
        end
        last = cyc;
      end
    end
  end

  // Memory model: variable latency, handshake stability checks, store scoreboard.
  initial begin
    logic        prev_req, prev_ack, is_data, hang;
    logic [31:0] cap_addr, cap_wdata;
    int          cnt, dly;
    prev_req = 1'b0; prev_ack = 1'b0; cnt = 0;
    cap_addr = 32'h0; cap_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mem_ack = 1'b0; cnt = 0; prev_req = 1'b0; prev_ack = 1'b0; data_req_cnt = 0;
      end else begin
        if (prev_ack) chk("idle_after_ack", {31'h0, mem_req}, 32'h0);
        if (mem_req) begin
          is_data = (mem_addr >= 32'h100);
          if (prev_req && !prev_ack) begin
            chk("req_stable_addr", mem_addr, cap_addr);
            if (mem_we) chk("req_stable_wdata", mem_wdata, cap_wdata);
          end else begin
            cap_addr = mem_addr;
            cap_wdata = mem_wdata;
            if (is_data) data_req_cnt++;
          end
          dly  = is_data ? data_delay : fetch_delay;
          hang = is_data ? hang_data : hang_fetch;
          if (hang || cnt < dly) begin
            mem_ack = 1'b0;
            cnt++;
          end else begin
            mem_ack = 1'b1;
            cnt = 0;
            if (mem_we) begin
              mem[mem_addr[9:2]] = mem_wdata;
              if (exp_wa_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: actual addr=%h data=%h required none", mem_addr, mem_wdata);
              end else begin
                chk("store_addr", mem_addr, exp_wa_q.pop_front());
                chk("store_data", mem_wdata, exp_wd_q.pop_front());
              end
            end else begin
              mem_rdata = mem[mem_addr[9:2]];
            end
          end
        end else begin
          mem_ack = 1'b0;
          cnt = 0;
        end
        prev_req = mem_req;
        prev_ack = mem_ack;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc_out", pc_out, PC_INIT);
    chk("rst_outputs", {26'h0, mem_req, mem_we, retire, halted, fault, 1'b0}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    reset = 1'b1;
  endtask

  task automatic wait_halt();
    int n;
    n = 0;
    while (!halted && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("halted", {31'h0, halted}, 32'h1);
    repeat (4) @(negedge clk);
  endtask

  task automatic end_phase();
    chk("pending_retires", 32'(exp_pc_q.size()), 32'h0);
    chk("pending_stores", 32'(exp_wa_q.size()), 32'h0);
  endtask

  initial begin
    int n, reqs;

    // ALU sequence with immediate ack, then BREAK.
    clear_mem();
    mem[0] = i_t(6'h09, 0, 8, 16'd5);
    mem[1] = r_t(8, 8, 9, 0, 6'h21);
    mem[2] = i_t(6'h2B, 0, 9, 16'h0100);
    mem[3] = BRK;
    exp_ret(32'h04, 0); exp_ret(32'h08, 4); exp_ret(32'h0C, 0);
    exp_wr(32'h100, 32'd10);
    do_reset();
    wait_halt();
    chk("break_fault", {31'h0, fault}, 32'h0);
    chk("halt_pc_frozen", pc_out, 32'h0C);
    chk("halt_no_req", {31'h0, mem_req}, 32'h0);
    end_phase();

    // Store/load with three data wait states.
    clear_mem();
    data_delay = 3;
    mem[0] = i_t(6'h09, 0, 9, 16'd10);
    mem[1] = i_t(6'h2B, 0, 9, 16'h0100);
    mem[2] = NOP;
    mem[3] = i_t(6'h23, 0, 10, 16'h0100);
    mem[4] = i_t(6'h2B, 0, 10, 16'h0104);
    mem[5] = i_t(6'h2B, 0, 29, 16'h0108);
    mem[6] = BRK;
    exp_ret(32'h04, 0); exp_ret(32'h08, 0); exp_ret(32'h0C, 0);
    exp_ret(32'h10, 8); exp_ret(32'h14, 0); exp_ret(32'h18, 0);
    exp_wr(32'h100, 32'd10); exp_wr(32'h104, 32'd10); exp_wr(32'h108, SP_INIT);
    do_reset();
    wait_halt();
    chk("mem_phase_fault", {31'h0, fault}, 32'h0);
    end_phase();
    data_delay = 0;

    // Branches, jumps and the remaining ALU operations.
    clear_mem();
    mem[0]       = i_t(6'h04, 8, 8, 16'd2);
    mem[3]       = i_t(6'h05, 0, 0, 16'd5);
    mem[4]       = r_t(31, 0, 0, 0, 6'h08);
    mem[16]      = {6'h02, 26'h20};
    mem[32]      = i_t(6'h09, 0, 11, 16'hFFFF);
    mem[33]      = r_t(11, 0, 12, 0, 6'h2A);
    mem[34]      = r_t(0, 12, 13, 5, 6'h00);
    mem[35]      = r_t(13, 12, 14, 0, 6'h23);
    mem[36]      = r_t(11, 13, 15, 0, 6'h24);
    mem[37]      = r_t(14, 13, 16, 0, 6'h25);
    mem[38]      = i_t(6'h2B, 0, 12, 16'h0100);
    mem[39]      = i_t(6'h2B, 0, 14, 16'h0104);
    mem[40]      = i_t(6'h2B, 0, 15, 16'h0108);
    mem[41]      = i_t(6'h2B, 0, 16, 16'h010C);
    mem[42]      = r_t(0, 11, 17, 0, 6'h2A);
    mem[43]      = i_t(6'h2B, 0, 17, 16'h0110);
    mem[44]      = BRK;
    exp_ret(32'h0C, 0); exp_ret(32'h10, 3); exp_ret(32'h40, 3); exp_ret(32'h80, 3);
    exp_ret(32'h84, 4); exp_ret(32'h88, 4); exp_ret(32'h8C, 4); exp_ret(32'h90, 4);
    exp_ret(32'h94, 4); exp_ret(32'h98, 4); exp_ret(32'h9C, 0); exp_ret(32'hA0, 0);
    exp_ret(32'hA4, 0); exp_ret(32'hA8, 0); exp_ret(32'hAC, 0); exp_ret(32'hB0, 0);
    exp_wr(32'h100, 32'd1); exp_wr(32'h104, 32'd31); exp_wr(32'h108, 32'd32);
    exp_wr(32'h10C, 32'd63); exp_wr(32'h110, 32'd0);
    do_reset();
    wait_halt();
    chk("branch_phase_fault", {31'h0, fault}, 32'h0);
    end_phase();

    // Misaligned load address.
    clear_mem();
    mem[0] = i_t(6'h23, 0, 10, 16'h0102);
    do_reset();
    wait_halt();
    chk("misalign_fault", {31'h0, fault}, 32'h1);
    chk("misalign_no_mem", 32'(data_req_cnt), 32'h0);
    chk("misalign_no_retire", 32'(retire_cnt), 32'h0);
    end_phase();

    // Unknown opcode.
    clear_mem();
    mem[0] = {6'h3F, 26'h0};
    do_reset();
    wait_halt();
    chk("illegal_fault", {31'h0, fault}, 32'h1);
    chk("illegal_no_retire", 32'(retire_cnt), 32'h0);

    // Watchdog: fetch never acknowledged.
    clear_mem();
    hang_fetch = 1'b1;
    do_reset();
    n = 0;
    reqs = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (fault) break;
      if (mem_req) reqs++;
    end
    chk("wd_req_cycles", 32'(reqs), 32'd16);
    chk("wd_fault", {31'h0, fault}, 32'h1);
    chk("wd_req_drop", {31'h0, mem_req}, 32'h0);
    chk("wd_halted", {31'h0, halted}, 32'h1);
    hang_fetch = 1'b0;

    // Reset in the middle of a stalled store.
    clear_mem();
    hang_data = 1'b1;
    mem[0] = i_t(6'h09, 0, 29, 16'd7);
    mem[1] = i_t(6'h2B, 0, 29, 16'h0100);
    exp_ret(32'h04, 0);
    do_reset();
    n = 0;
    while (!(mem_req && mem_we) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_store", {31'h0, mem_req & mem_we}, 32'h1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("reset_drops_req", {31'h0, mem_req}, 32'h0);
    chk("reset_no_retire", {31'h0, retire}, 32'h0);
    clear_mem();
    hang_data = 1'b0;
    mem[0] = i_t(6'h2B, 0, 29, 16'h0104);
    mem[1] = BRK;
    exp_ret(32'h04, 0);
    exp_wr(32'h104, SP_INIT);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (!mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("refetch_addr", mem_addr, PC_INIT);
    wait_halt();
    chk("post_reset_fault", {31'h0, fault}, 32'h0);
    end_phase();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
